// File: rtl/qspi_arbiter_pkg.sv
// Shared types for the two-port QSPI arbiter: FSM states, port count,
// access-size encoding, pending-slot record and the grant selection helper.
package qspi_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int ADR_W     = 32;
    localparam int DATA_W    = 32;

    // Access size as carried on m_size: {w, hw}; 2'b00 is a byte access.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HW   = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        XFER_READ  = 1'b0,
        XFER_WRITE = 1'b1
    } xfer_kind_e;

    typedef struct packed {
        logic w;
        logic hw;
    } acc_size_t;

    typedef struct packed {
        xfer_kind_e          kind;
        acc_size_t           size;
        logic [ADR_W-1:0]    adr;
        logic [DATA_W-1:0]   wdata;
    } slot_t;

    // Port 0 wins unless rotation is enabled and both ports are waiting,
    // in which case the port that was not granted last goes first.
    function automatic logic pick_grant(input logic [NUM_PORTS-1:0] full,
                                        input logic                 last,
                                        input logic                 rr_en);
        logic g;
        if (rr_en && full[0] && full[1]) begin
            g = ~last;
        end else if (full[0]) begin
            g = 1'b0;
        end else begin
            g = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/qspi_arbiter_if.sv
// Bus bundle of the arbiter: upstream port signals plus downstream qspi_if side.
// slave = arbiter view, master = view of the surrounding masters and qspi_if.
interface qspi_arbiter_if;
    import qspi_arbiter_pkg::*;

    logic [NUM_PORTS-1:0]          m_read_req;
    logic [NUM_PORTS-1:0]          m_write_req;
    logic [2*NUM_PORTS-1:0]        m_size;
    logic [ADR_W*NUM_PORTS-1:0]    m_adr;
    logic [DATA_W*NUM_PORTS-1:0]   m_wdata;
    logic [NUM_PORTS-1:0]          m_read_valid;
    logic [DATA_W-1:0]             m_read_data;
    logic [NUM_PORTS-1:0]          m_write_finish;
    logic                          timeout_err;

    logic                          read_req;
    logic                          write_req;
    logic                          read_w;
    logic                          read_hw;
    logic                          write_w;
    logic                          write_hw;
    logic [ADR_W-1:0]              read_adr;
    logic [ADR_W-1:0]              write_adr;
    logic [DATA_W-1:0]             write_data;
    logic                          read_valid;
    logic                          write_finish;
    logic [DATA_W-1:0]             read_data;

    modport slave (
        input  m_read_req, m_write_req, m_size, m_adr, m_wdata,
        input  read_valid, write_finish, read_data,
        output m_read_valid, m_read_data, m_write_finish, timeout_err,
        output read_req, write_req, read_w, read_hw, write_w, write_hw,
        output read_adr, write_adr, write_data
    );

    modport master (
        output m_read_req, m_write_req, m_size, m_adr, m_wdata,
        output read_valid, write_finish, read_data,
        input  m_read_valid, m_read_data, m_write_finish, timeout_err,
        input  read_req, write_req, read_w, read_hw, write_w, write_hw,
        input  read_adr, write_adr, write_data
    );

endinterface

// File: rtl/qspi_arb_slot.sv
// One-deep pending request slot for a single upstream port; a write pulse
// wins over a simultaneous read pulse and requests into a full slot are dropped.
module qspi_arb_slot
    import qspi_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               read_pulse,
    input  logic               write_pulse,
    input  logic [1:0]         size,
    input  logic [ADR_W-1:0]   adr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               clr,
    output logic               full,
    output slot_t              slot
);

    logic  full_r;
    slot_t slot_r;

    // Capture a request into an empty slot; the arbiter clears it when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            slot_r <= '0;
        end else if (clr) begin
            full_r <= 1'b0;
        end else if (!full_r && (read_pulse || write_pulse)) begin
            full_r       <= 1'b1;
            slot_r.kind  <= write_pulse ? XFER_WRITE : XFER_READ;
            slot_r.size  <= acc_size_t'(size);
            slot_r.adr   <= adr;
            slot_r.wdata <= wdata;
        end else begin
            full_r <= full_r;
        end
    end

    assign full = full_r;
    assign slot = slot_r;

endmodule

// File: rtl/qspi_arbiter.sv
// Two-port arbiter in front of qspi_if: one outstanding downstream transaction,
// fixed priority by default, round-robin when QSPI_ARB_RR_EN is defined.
module qspi_arbiter
    import qspi_arbiter_pkg::*;
#(
    parameter int TO_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    qspi_arbiter_if.slave   bus
);

    localparam int              CNT_W   = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);
`ifdef QSPI_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic [NUM_PORTS-1:0] slot_full_s;
    slot_t                slot_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] slot_clr_s;
    logic                 grant_s;
    slot_t                sel_slot_s;

    arb_state_e           state_r;
    logic                 gnt_r;
    logic                 last_r;
    xfer_kind_e           kind_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 read_req_r;
    logic                 write_req_r;
    logic                 read_w_r;
    logic                 read_hw_r;
    logic                 write_w_r;
    logic                 write_hw_r;
    logic [ADR_W-1:0]     read_adr_r;
    logic [ADR_W-1:0]     write_adr_r;
    logic [DATA_W-1:0]    write_data_r;
    logic [NUM_PORTS-1:0] m_read_valid_r;
    logic [DATA_W-1:0]    m_read_data_r;
    logic [NUM_PORTS-1:0] m_write_finish_r;
    logic                 timeout_err_r;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        qspi_arb_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .read_pulse  (bus.m_read_req[p]),
            .write_pulse (bus.m_write_req[p]),
            .size        (bus.m_size[2*p +: 2]),
            .adr         (bus.m_adr[ADR_W*p +: ADR_W]),
            .wdata       (bus.m_wdata[DATA_W*p +: DATA_W]),
            .clr         (slot_clr_s[p]),
            .full        (slot_full_s[p]),
            .slot        (slot_s[p])
        );
    end

    // Grant selection and slot release on the IDLE -> ISSUE transition.
    always_comb begin
        grant_s    = pick_grant(slot_full_s, last_r, RR_EN);
        slot_clr_s = '0;
        if (grant_s) begin
            sel_slot_s = slot_s[1];
        end else begin
            sel_slot_s = slot_s[0];
        end
        if ((state_r == ST_IDLE) && (|slot_full_s)) begin
            slot_clr_s[grant_s] = 1'b1;
        end else begin
            slot_clr_s = '0;
        end
    end

    // Arbiter FSM with all downstream and completion outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            gnt_r            <= 1'b0;
            last_r           <= 1'b0;
            kind_r           <= XFER_READ;
            cnt_r            <= '0;
            read_req_r       <= 1'b0;
            write_req_r      <= 1'b0;
            read_w_r         <= 1'b0;
            read_hw_r        <= 1'b0;
            write_w_r        <= 1'b0;
            write_hw_r       <= 1'b0;
            read_adr_r       <= '0;
            write_adr_r      <= '0;
            write_data_r     <= '0;
            m_read_valid_r   <= '0;
            m_read_data_r    <= '0;
            m_write_finish_r <= '0;
            timeout_err_r    <= 1'b0;
        end else begin
            read_req_r       <= 1'b0;
            write_req_r      <= 1'b0;
            m_read_valid_r   <= '0;
            m_read_data_r    <= '0;
            m_write_finish_r <= '0;
            timeout_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|slot_full_s) begin
                        gnt_r   <= grant_s;
                        last_r  <= grant_s;
                        kind_r  <= sel_slot_s.kind;
                        state_r <= ST_ISSUE;
                        if (sel_slot_s.kind == XFER_WRITE) begin
                            write_req_r  <= 1'b1;
                            write_w_r    <= sel_slot_s.size.w;
                            write_hw_r   <= sel_slot_s.size.hw;
                            write_adr_r  <= sel_slot_s.adr;
                            write_data_r <= sel_slot_s.wdata;
                        end else begin
                            read_req_r   <= 1'b1;
                            read_w_r     <= sel_slot_s.size.w;
                            read_hw_r    <= sel_slot_s.size.hw;
                            read_adr_r   <= sel_slot_s.adr;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real completion beats a timeout landing in the same cycle.
                    if ((kind_r == XFER_READ) && bus.read_valid) begin
                        m_read_valid_r[gnt_r] <= 1'b1;
                        m_read_data_r         <= bus.read_data;
                        state_r               <= ST_IDLE;
                    end else if ((kind_r == XFER_WRITE) && bus.write_finish) begin
                        m_write_finish_r[gnt_r] <= 1'b1;
                        state_r                 <= ST_IDLE;
                    end else if (cnt_r == TO_LAST) begin
                        if (kind_r == XFER_READ) begin
                            m_read_valid_r[gnt_r] <= 1'b1;
                        end else begin
                            m_write_finish_r[gnt_r] <= 1'b1;
                        end
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.read_req       = read_req_r;
    assign bus.write_req      = write_req_r;
    assign bus.read_w         = read_w_r;
    assign bus.read_hw        = read_hw_r;
    assign bus.write_w        = write_w_r;
    assign bus.write_hw       = write_hw_r;
    assign bus.read_adr       = read_adr_r;
    assign bus.write_adr      = write_adr_r;
    assign bus.write_data     = write_data_r;
    assign bus.m_read_valid   = m_read_valid_r;
    assign bus.m_read_data    = m_read_data_r;
    assign bus.m_write_finish = m_write_finish_r;
    assign bus.timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed bench for qspi_arbiter with TO_CYC=8; the arbitration-order
// expectation follows QSPI_ARB_RR_EN when the bench is built with it.
module tb_qspi_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    logic first_port;

    qspi_arbiter_if bus ();

    qspi_arbiter #(.TO_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rreq"},   64'(bus.read_req),       64'd0);
        check_eq({tag, "_wreq"},   64'(bus.write_req),      64'd0);
        check_eq({tag, "_size"},   64'({bus.read_w, bus.read_hw, bus.write_w, bus.write_hw}), 64'd0);
        check_eq({tag, "_radr"},   64'(bus.read_adr),       64'd0);
        check_eq({tag, "_wadr"},   64'(bus.write_adr),      64'd0);
        check_eq({tag, "_wdat"},   64'(bus.write_data),     64'd0);
        check_eq({tag, "_mrv"},    64'(bus.m_read_valid),   64'd0);
        check_eq({tag, "_mrd"},    64'(bus.m_read_data),    64'd0);
        check_eq({tag, "_mwf"},    64'(bus.m_write_finish), 64'd0);
        check_eq({tag, "_to"},     64'(bus.timeout_err),    64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        bus.m_read_req   = 2'b00;
        bus.m_write_req  = 2'b00;
        bus.m_size       = 4'b0000;
        bus.m_adr        = 64'd0;
        bus.m_wdata      = 64'd0;
        bus.read_valid   = 1'b0;
        bus.write_finish = 1'b0;
        bus.read_data    = 32'd0;
`ifdef QSPI_ARB_RR_EN
        first_port = 1'b1;
`else
        first_port = 1'b0;
`endif

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Port 0 word read: request at T, downstream pulse at T+2.
        bus.m_read_req = 2'b01;
        bus.m_adr      = {32'h0, 32'h0000_0100};
        bus.m_size     = 4'b0010;
        tick();
        bus.m_read_req = 2'b00;
        check_eq("rd_t1_req", 64'(bus.read_req), 64'd0);
        tick();
        check_eq("rd_t2_req", 64'(bus.read_req), 64'd1);
        check_eq("rd_t2_adr", 64'(bus.read_adr), 64'h100);
        check_eq("rd_t2_w",   64'({bus.read_w, bus.read_hw}), 64'b10);
        tick();
        check_eq("rd_wait_req", 64'(bus.read_req), 64'd0);
        check_eq("rd_wait_adr", 64'(bus.read_adr), 64'h100);
        bus.read_valid = 1'b1;
        bus.read_data  = 32'hDEAD_BEEF;
        tick();
        bus.read_valid = 1'b0;
        check_eq("rd_done_v", 64'(bus.m_read_valid), 64'b01);
        check_eq("rd_done_d", 64'(bus.m_read_data),  64'hDEAD_BEEF);
        tick();
        check_eq("rd_after_v", 64'(bus.m_read_valid), 64'b00);

        // Both ports write together; last grant was port 0.
        bus.m_write_req = 2'b11;
        bus.m_adr       = {32'h0000_0300, 32'h0000_0200};
        bus.m_wdata     = {32'h1111_1111, 32'h2222_2222};
        bus.m_size      = 4'b0100;
        tick();
        bus.m_write_req = 2'b00;
        tick();
        check_eq("wr1_req", 64'(bus.write_req), 64'd1);
        check_eq("wr1_adr", 64'(bus.write_adr), first_port ? 64'h300 : 64'h200);
        check_eq("wr1_dat", 64'(bus.write_data), first_port ? 64'h1111_1111 : 64'h2222_2222);
        check_eq("wr1_sz",  64'({bus.write_w, bus.write_hw}), first_port ? 64'b01 : 64'b00);
        tick();
        bus.write_finish = 1'b1;
        tick();
        bus.write_finish = 1'b0;
        check_eq("wr1_fin", 64'(bus.m_write_finish), first_port ? 64'b10 : 64'b01);
        check_eq("wr1_idle_req", 64'(bus.write_req), 64'd0);
        tick();
        check_eq("wr2_req", 64'(bus.write_req), 64'd1);
        check_eq("wr2_adr", 64'(bus.write_adr), first_port ? 64'h200 : 64'h300);
        check_eq("wr2_fin_clr", 64'(bus.m_write_finish), 64'b00);
        tick();
        bus.write_finish = 1'b1;
        tick();
        bus.write_finish = 1'b0;
        check_eq("wr2_fin", 64'(bus.m_write_finish), first_port ? 64'b01 : 64'b10);

        // Port 1 half-word read with no response: timeout on the 8th WAIT cycle.
        tick();
        bus.m_read_req = 2'b10;
        bus.m_adr      = {32'h0000_0400, 32'h0};
        bus.m_size     = 4'b0100;
        tick();
        bus.m_read_req = 2'b00;
        tick();
        check_eq("to_req", 64'(bus.read_req), 64'd1);
        check_eq("to_hw",  64'({bus.read_w, bus.read_hw}), 64'b01);
        bus.read_data = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("to_early", 64'({bus.timeout_err, bus.m_read_valid}), 64'd0);
        end
        tick();
        check_eq("to_err",  64'(bus.timeout_err),  64'd1);
        check_eq("to_mrv",  64'(bus.m_read_valid), 64'b10);
        check_eq("to_data", 64'(bus.m_read_data),  64'd0);
        bus.read_valid = 1'b1;
        tick();
        bus.read_valid = 1'b0;
        check_eq("late_mrv", 64'(bus.m_read_valid), 64'b00);
        check_eq("late_err", 64'(bus.timeout_err),  64'd0);
        tick();
        check_eq("late_req", 64'(bus.read_req), 64'd0);

        // Completion on the same cycle the timeout would fire: completion wins.
        bus.m_write_req = 2'b01;
        bus.m_adr       = {32'h0, 32'h0000_0500};
        tick();
        bus.m_write_req = 2'b00;
        tick();
        check_eq("tie_req", 64'(bus.write_req), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        bus.write_finish = 1'b1;
        tick();
        bus.write_finish = 1'b0;
        check_eq("tie_fin", 64'(bus.m_write_finish), 64'b01);
        check_eq("tie_err", 64'(bus.timeout_err),    64'd0);

        // Reset in WAIT with port 1 queued: nothing completes or issues afterwards.
        tick();
        bus.m_write_req = 2'b01;
        bus.m_adr       = {32'h0000_0700, 32'h0000_0600};
        tick();
        bus.m_write_req = 2'b00;
        tick();
        check_eq("rst_issue", 64'(bus.write_req), 64'd1);
        tick();
        bus.m_read_req = 2'b10;
        tick();
        bus.m_read_req = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_wait");
        bus.write_finish = 1'b1;
        bus.read_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rst_quiet", 64'({bus.read_req, bus.write_req, bus.m_read_valid,
                                       bus.m_write_finish, bus.timeout_err}), 64'd0);
        end
        bus.write_finish = 1'b0;
        bus.read_valid   = 1'b0;

        // Read and write pulse together on port 0: only the write is issued.
        bus.m_read_req  = 2'b01;
        bus.m_write_req = 2'b01;
        bus.m_adr       = {32'h0, 32'h0000_0800};
        tick();
        bus.m_read_req  = 2'b00;
        bus.m_write_req = 2'b00;
        tick();
        check_eq("rw_wreq", 64'(bus.write_req), 64'd1);
        check_eq("rw_rreq", 64'(bus.read_req),  64'd0);
        check_eq("rw_wadr", 64'(bus.write_adr), 64'h800);
        tick();
        bus.write_finish = 1'b1;
        tick();
        bus.write_finish = 1'b0;
        check_eq("rw_fin", 64'(bus.m_write_finish), 64'b01);
        check_eq("rw_mrv", 64'(bus.m_read_valid),   64'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rw_no_read", 64'(bus.read_req), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/qspi_arbiter.md
QSPI_ARBITER -- requirements
Module: qspi_arbiter

Interface
REQ-001 Parameter TO_CYC, default 1023: number of WAIT cycles before a downstream transaction times out.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 m_read_req  in  2  per-port read request pulse, one cycle wide; bit n is port n.
REQ-005 m_write_req  in  2  per-port write request pulse, one cycle wide.
REQ-006 m_size  in  4  per-port access size {w,hw} at bits [2n+1:2n]; 00 is byte.
REQ-007 m_adr  in  64  per-port byte address at bits [32n+31:32n].
REQ-008 m_wdata  in  64  per-port write data at bits [32n+31:32n].
REQ-009 m_read_valid  out  2  per-port read completion pulse.
REQ-010 m_read_data  out  32  read data, shared by both ports, qualified by m_read_valid.
REQ-011 m_write_finish  out  2  per-port write completion pulse.
REQ-012 timeout_err  out  1  one-cycle pulse on a timed-out transaction.
REQ-013 read_req, write_req  out  1 each  downstream request pulses to qspi_if.
REQ-014 read_w, read_hw, write_w, write_hw  out  1 each  downstream size qualifiers.
REQ-015 read_adr, write_adr, write_data  out  32 each  downstream address and data.
REQ-016 read_valid, write_finish  in  1 each  downstream completions.
REQ-017 read_data  in  32  downstream read data.

Function
REQ-018 Each port SHALL have one pending slot holding {type, size, adr, wdata}, captured on a request pulse and visible in the next cycle.
- Request to a port whose slot is already full: ignored.
- Simultaneous read and write pulse on one port: write captured, read dropped.
REQ-019 FSM states SHALL be IDLE, ISSUE and WAIT.
- IDLE -> ISSUE when any slot is full: latch grant g, clear slot g.
- ISSUE -> WAIT after exactly one cycle.
- WAIT -> IDLE on completion or timeout.
REQ-020 The downstream read_req or write_req SHALL be a registered one-cycle pulse asserted only in ISSUE, with size, address and data held stable from ISSUE through WAIT.
REQ-021 A request pulse at cycle T into an idle arbiter SHALL produce the downstream request pulse at cycle T+2.
REQ-022 A downstream read_valid or write_finish in WAIT at cycle C SHALL produce a registered m_read_valid[g] (with m_read_data) or m_write_finish[g] at C+1; the FSM is in IDLE at C+1, so the next downstream request is no earlier than C+2.
REQ-023 Arbitration SHALL be fixed priority, port 0 over port 1, unless the configuration macro in REQ-030 is defined.
REQ-024 A WAIT-cycle counter SHALL reach TO_CYC as the timeout.
- On timeout: completion pulse to g with m_read_data=0, timeout_err pulse in the same cycle, return to IDLE.
- A downstream completion in the same cycle as timeout takes precedence; no error is raised.
REQ-025 Downstream completions arriving in IDLE or ISSUE SHALL be ignored.
REQ-026 At most one downstream transaction SHALL be outstanding at any time.

Reset
REQ-027 While rst_n=0 at a clock edge, the arbiter SHALL clear the FSM to IDLE, clear both slots and the counter, and set the round-robin pointer to port 0.
REQ-028 All outputs SHALL be 0 after reset; a transaction in flight is abandoned and produces no completion.
REQ-029 The arbiter SHALL ignore late downstream responses after reset.

Configuration
REQ-030 With QSPI_ARB_RR_EN defined, arbitration SHALL be round-robin: the last granted port has lowest priority on a tie; without it, fixed priority per REQ-023.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the port count (2) and the size encoding {w,hw}.
REQ-032 One sub-module, qspi_arb_slot (pending slot capture and clear), SHALL be instantiated once per port.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Port 0 read pulse, adr=0x100, size=10 at T -> read_req at T+2 with read_adr=0x100, read_w=1; read_valid with 0xDEADBEEF -> m_read_valid=01 and data 0xDEADBEEF one cycle later.
- Both ports write in the same cycle, fixed priority -> port 0 issued first, port 1 issued at the earliest 1 cycle after m_write_finish[0].
- Same as previous with QSPI_ARB_RR_EN and last grant=0 -> port 1 issued first.
- TO_CYC=8, no downstream response -> timeout_err, m_read_valid[g] and data 0 at the 8th WAIT cycle; a late read_valid afterwards is ignored.
- rst_n=0 during WAIT -> all outputs 0 next cycle, slots empty, no completion pulse.
- Port 0 read and write pulse in the same cycle -> only write_req is issued.
